// File: rtl/memory_to_stream_dma_core.sv
`default_nettype none
// ============================================================================
// Module      : memory_to_stream_dma_core
// Description : Reads a byte range from memory through a burst read master
//               and streams it out as one packet of 64-byte beats. A small
//               CSR block sets the source, length and start/abort controls.
//               A credit counter stops a burst from being issued unless the
//               line buffer has room for it. Beats that return after an
//               abort or a reset are dropped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   csr_*                  : CSR slave, 4 x 64-bit words, read latency 1,
//                            never stalls
//                            0 SRC_ADDR[47:0] (bits [5:0] read as 0)
//                            1 LENGTH[19:0] in bytes
//                            2 CONTROL: bit0 GO, bit1 ABORT (self-clearing)
//                            3 STATUS: bit0 BUSY, bit1 DONE (write 1 to clear),
//                              bits [31:16] lines delivered
//   mem_read_*             : burst read master, 512-bit data, bursts of 1..4,
//                            no burst crosses a 256-byte boundary
//   m2s_st_source_*        : 512-bit packet stream source with SOP/EOP/empty
// ============================================================================
module memory_to_stream_dma_core #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  // CSR slave
  input  logic [1:0]   csr_address,
  input  logic         csr_read,
  input  logic         csr_write,
  input  logic [63:0]  csr_writedata,
  output logic [63:0]  csr_readdata,
  output logic         csr_readdatavalid,
  output logic         csr_waitrequest,
  // Read master
  output logic [47:0]  mem_read_address,
  output logic [2:0]   mem_read_burstcount,
  output logic         mem_read_read,
  input  logic         mem_read_waitrequest,
  input  logic [511:0] mem_read_readdata,
  input  logic         mem_read_readdatavalid,
  // Stream source
  output logic [511:0] m2s_st_source_data,
  output logic         m2s_st_source_valid,
  input  logic         m2s_st_source_ready,
  output logic         m2s_st_source_startofpacket,
  output logic         m2s_st_source_endofpacket,
  output logic [5:0]   m2s_st_source_empty
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;
  localparam logic [1:0] c_S_ABORT = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [47:0]     r_src_addr;
  logic [19:0]     r_length;
  logic            r_done;
  logic [63:0]     r_csr_rdata;
  logic            r_csr_rdv;

  logic [47:0]     r_rd_addr;
  logic [2:0]      r_rd_burst;
  logic            r_rd_read;
  logic [14:0]     r_lines_left;   // lines not yet requested
  logic [14:0]     r_total_lines;  // N for the running packet
  logic [14:0]     r_beat_cnt;     // beats handed to the sink
  logic [c_CW-1:0] r_credit;       // free entries minus outstanding beats
  logic [c_CW-1:0] r_outstanding;  // requested beats not yet returned

  logic [511:0]    r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [1:0]      w_state_nxt;
  logic            w_busy;
  logic            w_issue_en;
  logic            w_push_en;
  logic            w_flush;
  logic            w_start;
  logic            w_done_set;

  logic            w_go;
  logic            w_abort;
  logic            w_len_nz;
  logic [20:0]     w_len_round;
  logic [14:0]     w_total;
  logic            w_rd_accept;
  logic            w_last_burst;
  logic            w_pop;
  logic            w_push;
  logic            w_ret;
  logic            w_last_beat;
  logic [2:0]      w_room;
  logic [2:0]      w_rem;
  logic [2:0]      w_burst;
  logic            w_can_issue;
  logic [c_CW-1:0] w_pop_ext;
  logic [c_CW-1:0] w_push_ext;
  logic [c_CW-1:0] w_acc_ext;
  logic [c_CW-1:0] w_ret_ext;
  logic [63:0]     w_csr_mux;
  logic            w_unused_ok;

  assign w_go     = csr_write && (csr_address == 2'd2) && csr_writedata[0];
  assign w_abort  = csr_write && (csr_address == 2'd2) && csr_writedata[1];
  assign w_len_nz = (r_length != 20'd0);

  // N = ceil(LENGTH / 64); widened by one bit so LENGTH near 2^20 cannot wrap
  assign w_len_round = {1'b0, r_length} + 21'd63;
  assign w_total     = w_len_round[20:6];

  assign w_rd_accept  = r_rd_read && !mem_read_waitrequest;
  assign w_last_burst = (r_lines_left == {12'd0, r_rd_burst});

  assign w_pop       = (r_count != '0) && m2s_st_source_ready;
  assign w_push      = w_push_en && mem_read_readdatavalid;
  assign w_ret       = mem_read_readdatavalid && (r_outstanding != '0);
  assign w_last_beat = (r_beat_cnt == (r_total_lines - 15'd1));

  // Burst = min(4, lines left, lines left before the next 256-byte boundary)
  assign w_room  = 3'd4 - {1'b0, r_rd_addr[7:6]};
  assign w_rem   = (r_lines_left > 15'd3) ? 3'd4 : r_lines_left[2:0];
  assign w_burst = (w_rem < w_room) ? w_rem : w_room;

  assign w_can_issue = w_issue_en && !r_rd_read && (r_lines_left != 15'd0) &&
                       (r_credit >= {{(c_CW-3){1'b0}}, w_burst});

  assign w_pop_ext  = {{(c_CW-1){1'b0}}, w_pop};
  assign w_push_ext = {{(c_CW-1){1'b0}}, w_push};
  assign w_ret_ext  = {{(c_CW-1){1'b0}}, w_ret};
  assign w_acc_ext  = w_rd_accept ? {{(c_CW-3){1'b0}}, r_rd_burst} : '0;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin : p_state_reg
    if (!reset_reset_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin : p_state_nxt
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_go && w_len_nz) w_state_nxt = c_S_ISSUE;
      end
      c_S_ISSUE: begin
        if (w_abort)                         w_state_nxt = c_S_ABORT;
        else if (w_rd_accept && w_last_burst) w_state_nxt = c_S_DRAIN;
      end
      c_S_DRAIN: begin
        if (w_abort)                 w_state_nxt = c_S_ABORT;
        else if (w_pop && w_last_beat) w_state_nxt = c_S_IDLE;
      end
      c_S_ABORT: begin
        // A request already on the bus must finish its handshake and every
        // beat it asked for must come back before the engine can be reused.
        if (!r_rd_read && (r_outstanding == '0)) w_state_nxt = c_S_IDLE;
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin : p_state_out
    w_busy     = 1'b0;
    w_issue_en = 1'b0;
    w_push_en  = 1'b0;
    w_flush    = 1'b0;
    w_start    = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        w_start    = w_go && w_len_nz;
        w_done_set = w_go && !w_len_nz;
      end
      c_S_ISSUE: begin
        w_busy     = 1'b1;
        w_issue_en = !w_abort;
        w_push_en  = 1'b1;
        w_flush    = w_abort;
      end
      c_S_DRAIN: begin
        w_busy     = 1'b1;
        w_push_en  = 1'b1;
        w_flush    = w_abort;
        w_done_set = !w_abort && w_pop && w_last_beat;
      end
      c_S_ABORT: begin
        w_busy     = 1'b1;
      end
      default: begin
        w_busy     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CSR block
  // --------------------------------------------------------------------------
  always_comb begin : p_csr_mux
    w_csr_mux = 64'd0;
    case (csr_address)
      2'd0:    w_csr_mux = {16'd0, r_src_addr};
      2'd1:    w_csr_mux = {44'd0, r_length};
      2'd3:    w_csr_mux = {32'd0, 1'b0, r_beat_cnt, 14'd0, r_done, w_busy};
      default: w_csr_mux = 64'd0;
    endcase
  end

  always_ff @(posedge clk_clk) begin : p_csr
    if (!reset_reset_n) begin
      r_src_addr  <= 48'd0;
      r_length    <= 20'd0;
      r_done      <= 1'b0;
      r_csr_rdata <= 64'd0;
      r_csr_rdv   <= 1'b0;
    end else begin
      if (csr_write && !w_busy) begin
        if (csr_address == 2'd0) r_src_addr <= {csr_writedata[47:6], 6'd0};
        if (csr_address == 2'd1) r_length   <= csr_writedata[19:0];
      end

      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_start) begin
        r_done <= 1'b0;
      end else if (csr_write && (csr_address == 2'd3) && csr_writedata[1]) begin
        r_done <= 1'b0;
      end

      r_csr_rdv <= csr_read;
      if (csr_read) r_csr_rdata <= w_csr_mux;
    end
  end

  // --------------------------------------------------------------------------
  // Read issue, credit and beat accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin : p_issue
    if (!reset_reset_n) begin
      r_rd_addr     <= 48'd0;
      r_rd_burst    <= 3'd0;
      r_rd_read     <= 1'b0;
      r_lines_left  <= 15'd0;
      r_total_lines <= 15'd0;
      r_beat_cnt    <= 15'd0;
      r_credit      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_start) begin
        r_rd_addr     <= r_src_addr;
        r_lines_left  <= w_total;
        r_total_lines <= w_total;
        r_beat_cnt    <= 15'd0;
        r_credit      <= c_DEPTH;
      end else begin
        // Request fields are only touched when no request is pending or on
        // its accept edge, so they stay put across waitrequest stalls.
        if (w_rd_accept) begin
          r_rd_read    <= 1'b0;
          r_rd_addr    <= r_rd_addr + {39'd0, r_rd_burst, 6'd0};
          r_lines_left <= r_lines_left - {12'd0, r_rd_burst};
        end else if (w_can_issue) begin
          r_rd_read  <= 1'b1;
          r_rd_burst <= w_burst;
        end
        // A returned beat moves from outstanding into the buffer, which
        // leaves credit unchanged; only accepts and pops move it.
        r_credit <= r_credit + w_pop_ext - w_acc_ext;
        if (w_pop) r_beat_cnt <= r_beat_cnt + 15'd1;
      end
      r_outstanding <= r_outstanding + w_acc_ext - w_ret_ext;
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin : p_fifo_mem
    if (w_push && !w_flush) r_mem[r_wr_ptr] <= mem_read_readdata;
  end

  always_ff @(posedge clk_clk) begin : p_fifo_ptr
    if (!reset_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + w_push_ext - w_pop_ext;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign csr_readdata      = r_csr_rdata;
  assign csr_readdatavalid = r_csr_rdv;
  assign csr_waitrequest   = 1'b0;

  assign mem_read_address    = r_rd_addr;
  assign mem_read_burstcount = r_rd_burst;
  assign mem_read_read       = r_rd_read;

  assign m2s_st_source_data          = r_mem[r_rd_ptr];
  assign m2s_st_source_valid         = (r_count != '0);
  assign m2s_st_source_startofpacket = (r_beat_cnt == 15'd0);
  assign m2s_st_source_endofpacket   = w_last_beat;
  // (64 - LENGTH[5:0]) mod 64 is the 6-bit two's complement of LENGTH[5:0]
  assign m2s_st_source_empty         = w_last_beat ? (6'd0 - r_length[5:0]) : 6'd0;

  assign w_unused_ok = &{1'b0, csr_writedata[63:48], 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_memory_to_stream_dma_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_to_stream_dma_core
// Description : Self-checking bench for memory_to_stream_dma_core. A memory
//               responder, a random-ready sink and a reference model of the
//               expected burst list and packet beats run alongside directed
//               scenarios and randomized transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_to_stream_dma_core;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   csr_address = 2'd0;
  logic         csr_read = 1'b0;
  logic         csr_write = 1'b0;
  logic [63:0]  csr_writedata = 64'd0;
  logic [63:0]  csr_readdata;
  logic         csr_readdatavalid;
  logic         csr_waitrequest;
  logic [47:0]  rd_address;
  logic [2:0]   rd_burstcount;
  logic         rd_read;
  logic         rd_waitrequest = 1'b0;
  logic [511:0] rd_readdata = '0;
  logic         rd_readdatavalid = 1'b0;
  logic [511:0] src_data;
  logic         src_valid;
  logic         src_ready = 1'b0;
  logic         src_sop;
  logic         src_eop;
  logic [5:0]   src_empty;

  always #5 clk = ~clk;

  memory_to_stream_dma_core #(.FIFO_DEPTH(DEPTH)) u_dut (
    .clk_clk                     (clk),
    .reset_reset_n               (rst_n),
    .csr_address                 (csr_address),
    .csr_read                    (csr_read),
    .csr_write                   (csr_write),
    .csr_writedata               (csr_writedata),
    .csr_readdata                (csr_readdata),
    .csr_readdatavalid           (csr_readdatavalid),
    .csr_waitrequest             (csr_waitrequest),
    .mem_read_address            (rd_address),
    .mem_read_burstcount         (rd_burstcount),
    .mem_read_read               (rd_read),
    .mem_read_waitrequest        (rd_waitrequest),
    .mem_read_readdata           (rd_readdata),
    .mem_read_readdatavalid      (rd_readdatavalid),
    .m2s_st_source_data          (src_data),
    .m2s_st_source_valid         (src_valid),
    .m2s_st_source_ready         (src_ready),
    .m2s_st_source_startofpacket (src_sop),
    .m2s_st_source_endofpacket   (src_eop),
    .m2s_st_source_empty         (src_empty)
  );

  typedef struct {logic [47:0] addr; logic [2:0] bc;} burst_t;
  typedef struct {logic [511:0] data; logic sop; logic eop; logic [5:0] empty;} beat_t;
  typedef struct {logic [511:0] data; int due;} ret_t;

  burst_t      exp_bursts[$];
  beat_t       exp_beats[$];
  ret_t        ret_q[$];
  logic [47:0] acc_addr_log[$];
  logic [2:0]  acc_bc_log[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wait_pct = 0, ready_pct = 100, rv_pct = 100, force_wait = 0;
  int sink_budget = 1 << 30;
  int popped = 0, inflight = 0, eop_count = 0, hold_cnt = 0;
  logic [5:0] last_eop_empty = '0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, got, exp);
  endtask

  // Memory content: every line is tagged with its own address
  function automatic logic [511:0] line_data(input logic [47:0] a);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = {a, 8'(k), 8'h5A};
    return d;
  endfunction

  // Reference model: expected bursts and beats for one transfer
  task automatic plan(input logic [47:0] src, input int len);
    int n, rem, idx, room, b;
    logic [47:0] a;
    n   = (len + 63) / 64;
    a   = {src[47:6], 6'd0};
    rem = n;
    idx = 0;
    while (rem > 0) begin
      room = 4 - int'(a[7:6]);
      b = (rem < 4) ? rem : 4;
      if (room < b) b = room;
      exp_bursts.push_back('{addr: a, bc: 3'(b)});
      for (int i = 0; i < b; i++) begin
        exp_beats.push_back('{data:  line_data(a + 48'(i * 64)),
                              sop:   (idx == 0),
                              eop:   (idx == n - 1),
                              empty: (idx == n - 1) ? 6'((64 - len % 64) % 64) : 6'd0});
        idx++;
      end
      a   = a + 48'(b * 64);
      rem = rem - b;
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [63:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [63:0] d);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    chk("csr_rdv", csr_readdatavalid, 1'b1);
    d = csr_readdata;
  endtask

  task automatic start_xfer(input logic [47:0] src, input int len);
    plan(src, len);
    acc_addr_log.delete();
    acc_bc_log.delete();
    inflight = 0; popped = 0; hold_cnt = 0;
    csr_wr(2'd0, {16'd0, src});
    csr_wr(2'd1, 64'(len));
    csr_wr(2'd2, 64'd1);
  endtask

  task automatic finish_xfer(input int n);
    logic [63:0] s;
    int k;
    s = '0; k = 0;
    while (!s[1] && k < 4000) begin csr_rd(2'd3, s); k++; end
    chk("done_set", s[1], 1'b1);
    chk("busy_clear", s[0], 1'b0);
    chk("lines_delivered", s[31:16], 16'(n));
    chk("beats_left", exp_beats.size(), 0);
    chk("bursts_left", exp_bursts.size(), 0);
    csr_wr(2'd3, 64'h2);
    csr_rd(2'd3, s);
    chk("done_w1c", s[1], 1'b0);
  endtask

  // Memory responder, sink and stream/bus monitors, all on the falling edge
  initial begin : p_env
    burst_t eb;
    beat_t  e;
    logic        prev_hold;
    logic [47:0] prev_addr;
    logic [2:0]  prev_bc;
    prev_hold = 1'b0; prev_addr = '0; prev_bc = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_hold && rst_n) begin
        hold_cnt++;
        chk("hold_read", rd_read, 1'b1);
        chk("hold_addr", rd_address, prev_addr);
        chk("hold_bc", rd_burstcount, prev_bc);
      end
      if (force_wait > 0 && rd_read) begin
        rd_waitrequest = 1'b1;
        force_wait--;
      end else begin
        rd_waitrequest = ($urandom_range(0, 99) < wait_pct);
      end
      prev_hold = rd_read && rd_waitrequest;
      prev_addr = rd_address;
      prev_bc   = rd_burstcount;
      if (rd_read && !rd_waitrequest && rst_n) begin
        acc_addr_log.push_back(rd_address);
        acc_bc_log.push_back(rd_burstcount);
        if (exp_bursts.size() == 0) begin
          chk("read_extra", 1'b1, 1'b0);
        end else begin
          eb = exp_bursts.pop_front();
          chk("rd_addr", rd_address, eb.addr);
          chk("rd_burst", rd_burstcount, eb.bc);
        end
        inflight += int'(rd_burstcount);
        chk("credit_bound", (inflight <= DEPTH), 1'b1);
        for (int i = 0; i < int'(rd_burstcount); i++)
          ret_q.push_back('{data: line_data(rd_address + 48'(i * 64)),
                            due:  cyc + 1 + int'($urandom_range(0, 3))});
      end
      if (ret_q.size() > 0 && ret_q[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
        rd_readdatavalid = 1'b1;
        rd_readdata      = ret_q[0].data;
        void'(ret_q.pop_front());
      end else begin
        rd_readdatavalid = 1'b0;
      end
      src_ready = (popped < sink_budget) && ($urandom_range(0, 99) < ready_pct);
      if (src_valid && src_ready && rst_n) begin
        popped++;
        inflight--;
        if (src_eop) begin eop_count++; last_eop_empty = src_empty; end
        if (exp_beats.size() == 0) begin
          chk("beat_extra", 1'b1, 1'b0);
        end else begin
          e = exp_beats.pop_front();
          chk("beat_data", src_data, e.data);
          chk("beat_sop", src_sop, e.sop);
          chk("beat_eop", src_eop, e.eop);
          chk("beat_empty", src_empty, e.empty);
        end
      end
    end
  end

  initial begin : p_watchdog
    #900000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    logic [63:0] s;
    logic [47:0] src;
    int k, len, eops;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read", rd_read, 1'b0);
    chk("rst_valid", src_valid, 1'b0);
    chk("rst_csr_rdv", csr_readdatavalid, 1'b0);
    chk("csr_waitreq", csr_waitrequest, 1'b0);
    rst_n = 1'b1;
    csr_rd(2'd3, s); chk("rst_status", s, 64'd0);
    csr_rd(2'd0, s); chk("rst_src", s, 64'd0);
    csr_rd(2'd1, s); chk("rst_len", s, 64'd0);

    // ---------------- aligned 256 bytes ----------------
    start_xfer(48'h1000, 256);
    finish_xfer(4);
    chk("t1_nbursts", acc_addr_log.size(), 1);
    chk("t1_addr", acc_addr_log[0], 48'h1000);
    chk("t1_bc", acc_bc_log[0], 3'd4);
    chk("t1_empty", last_eop_empty, 6'd0);
    csr_rd(2'd0, s); chk("src_readback", s, 64'h1000);

    // ---------------- boundary split, partial last line ----------------
    start_xfer(48'h10C0, 200);
    finish_xfer(4);
    chk("t2_nbursts", acc_addr_log.size(), 2);
    chk("t2_addr0", acc_addr_log[0], 48'h10C0);
    chk("t2_bc0", acc_bc_log[0], 3'd1);
    chk("t2_addr1", acc_addr_log[1], 48'h1100);
    chk("t2_bc1", acc_bc_log[1], 3'd3);
    chk("t2_empty", last_eop_empty, 6'd56);

    // ---------------- waitrequest held 5 cycles ----------------
    force_wait = 5;
    start_xfer(48'h2000, 256);
    finish_xfer(4);
    chk("t3_hold_cycles", hold_cnt, 5);

    // ---------------- backpressure, credit bound, GO while busy ----------------
    ready_pct = 0;
    start_xfer(48'h40000, 4096);
    repeat (300) @(negedge clk);
    chk("t4_no_pop", popped, 0);
    chk("t4_inflight_max", (inflight <= DEPTH) && (inflight > 0), 1'b1);
    csr_wr(2'd0, 64'h9000);
    csr_wr(2'd1, 64'd64);
    csr_wr(2'd2, 64'd1);
    csr_rd(2'd0, s); chk("t4_src_kept", s, 64'h40000);
    csr_rd(2'd1, s); chk("t4_len_kept", s, 64'd4096);
    ready_pct = 70;
    finish_xfer(64);
    ready_pct = 100;

    // ---------------- zero length ----------------
    eops = eop_count;
    csr_wr(2'd1, 64'd0);
    acc_addr_log.delete();
    @(negedge clk);
    csr_address = 2'd2; csr_writedata = 64'd1; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0; csr_address = 2'd3; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    chk("t5_rdv", csr_readdatavalid, 1'b1);
    chk("t5_done_next", csr_readdata[1:0], 2'b10);
    repeat (10) @(negedge clk);
    chk("t5_no_reads", acc_addr_log.size(), 0);
    chk("t5_no_beats", eop_count, eops);
    csr_wr(2'd3, 64'h2);

    // ---------------- abort after 2 of 8 beats ----------------
    start_xfer(48'h80000, 512);
    sink_budget = 2;
    k = 0;
    while (popped < 2 && k < 500) begin @(negedge clk); k++; end
    chk("t6_two_beats", popped, 2);
    csr_wr(2'd2, 64'd2);
    s = 64'd1; k = 0;
    while (s[0] && k < 500) begin csr_rd(2'd3, s); k++; end
    chk("t6_busy", s[0], 1'b0);
    chk("t6_done", s[1], 1'b0);
    chk("t6_lines", s[31:16], 16'd2);
    exp_bursts.delete();
    exp_beats.delete();
    sink_budget = 1 << 30;
    repeat (30) @(negedge clk);
    chk("t6_popped", popped, 2);
    chk("t6_valid", src_valid, 1'b0);
    chk("t6_no_eop", eop_count, eops);

    // ---------------- reset mid-transfer ----------------
    start_xfer(48'hC0000, 512);
    sink_budget = 1;
    k = 0;
    while (popped < 1 && k < 500) begin @(negedge clk); k++; end
    chk("t7_one_beat", popped, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_rst_read", rd_read, 1'b0);
    chk("t7_rst_valid", src_valid, 1'b0);
    rst_n = 1'b1;
    sink_budget = 1 << 30;
    k = 0;
    while (ret_q.size() > 0 && k < 100) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk("t7_valid_dropped", src_valid, 1'b0);
    chk("t7_no_eop", eop_count, eops);
    csr_rd(2'd3, s);
    chk("t7_status", s[1:0], 2'b00);
    exp_bursts.delete();
    exp_beats.delete();

    // ---------------- randomized transfers ----------------
    for (int t = 0; t < 8; t++) begin
      src = 48'({$urandom(), $urandom()});
      len = (t == 0) ? 64 : (t == 1) ? 1 : int'($urandom_range(1, 1500));
      wait_pct  = int'($urandom_range(0, 50));
      ready_pct = int'($urandom_range(30, 100));
      rv_pct    = int'($urandom_range(40, 100));
      start_xfer(src, len);
      finish_xfer((len + 63) / 64);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
